// File: rtl/loop_cnt_bank.sv
// loop_cnt_bank
//   Bank of N loop/pointer counters for the datapath. Each channel has its
//   own count, base (captured on load), limit and sticky done flag. A single
//   channel index selects which counter a command acts on and which counter
//   is shown on dout.
//
// Ports
//   Clk      in   clock, rising edge
//   RST      in   synchronous active-high reset (overrides all commands)
//   CH       in   [CW]  channel select for commands and dout/zero
//   Wen      in   load count[CH] from BusOut (may capture base)
//   Wlim     in   load limit[CH] from BusOut (independent of count commands)
//   Restore  in   count[CH] <- base[CH]
//   Inc      in   count[CH] += STEP
//   Dec      in   count[CH] -= STEP
//   BusOut   in   [W]   data bus
//   dout     out  [W]   count of selected channel (0 when CH >= N)
//   zero     out        selected count is 0 (1 when CH >= N)
//   done     out  [N]   sticky per-channel limit-reached flags
module loop_cnt_bank #(
    parameter int W            = 8,
    parameter int N            = 4,
    parameter int CW           = 2,
    parameter int STEP         = 1,
    parameter int SAT          = 0,
    parameter int BASE_ON_ZERO = 1
) (
    input  logic          Clk,
    input  logic          RST,
    input  logic [CW-1:0] CH,
    input  logic          Wen,
    input  logic          Wlim,
    input  logic          Restore,
    input  logic          Inc,
    input  logic          Dec,
    input  logic [W-1:0]  BusOut,
    output logic [W-1:0]  dout,
    output logic          zero,
    output logic [N-1:0]  done
);

    logic [W-1:0] count_q [N];
    logic [W-1:0] base_q  [N];
    logic [W-1:0] limit_q [N];
    logic [N-1:0] done_q;

    // Selected-channel view. An out-of-range CH matches no channel, so the
    // selected values default to 0 and no channel is written.
    logic [W-1:0] cur_count;
    logic [W-1:0] cur_base;
    logic [W-1:0] cur_limit;

    always_comb begin
        cur_count = '0;
        cur_base  = '0;
        cur_limit = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(CH) == i) begin
                cur_count = count_q[i];
                cur_base  = base_q[i];
                cur_limit = limit_q[i];
            end
        end
    end

    // Step arithmetic in W+1 bits so the carry/borrow is visible for
    // saturation.
    logic [W:0]   inc_full;
    logic [W:0]   dec_full;
    logic [W-1:0] inc_val;
    logic [W-1:0] dec_val;
    logic [W-1:0] step_val;
    logic         do_step;

    always_comb begin
        inc_full = {1'b0, cur_count} + (W+1)'(STEP);
        dec_full = {1'b0, cur_count} - (W+1)'(STEP);
        inc_val  = ((SAT != 0) && inc_full[W]) ? {W{1'b1}} : inc_full[W-1:0];
        dec_val  = ((SAT != 0) && dec_full[W]) ? {W{1'b0}} : dec_full[W-1:0];
        step_val = Inc ? inc_val : dec_val;
        // Inc together with Dec cancels out and the count holds.
        do_step  = !Wen && !Restore && (Inc ^ Dec);
    end

    always_ff @(posedge Clk) begin
        for (int i = 0; i < N; i++) begin
            if (RST) begin
                count_q[i] <= '0;
                base_q[i]  <= '0;
                limit_q[i] <= {W{1'b1}};
                done_q[i]  <= 1'b0;
            end else if (int'(CH) == i) begin
                if (Wen) begin
                    count_q[i] <= BusOut;
                    if ((BASE_ON_ZERO == 0) || (cur_count == '0))
                        base_q[i] <= BusOut;
                    done_q[i]  <= 1'b0;
                end else if (Restore) begin
                    count_q[i] <= cur_base;
                    done_q[i]  <= 1'b0;
                end else if (do_step) begin
                    count_q[i] <= step_val;
                    // Compared against the limit held before this edge, so a
                    // same-cycle Wlim does not affect this step.
                    if (step_val == cur_limit)
                        done_q[i] <= 1'b1;
                end
                if (Wlim)
                    limit_q[i] <= BusOut;
            end
        end
    end

    assign dout = cur_count;
    assign zero = (cur_count == '0);
    assign done = done_q;

endmodule

// File: tb/tb_loop_cnt_bank.sv
// Directed bench for loop_cnt_bank. Four instances share one stimulus bus:
//   u_main  : defaults (W=8, N=4, STEP=1, SAT=0, BASE_ON_ZERO=1)
//   u_sat   : SAT=1
//   u_step4 : STEP=4
//   u_n3    : N=3, CW=2 (CH=3 is out of range)
// Each segment checks only the instance(s) whose state it tracks.
module tb_loop_cnt_bank;

  logic       Clk = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] CH = '0;
  logic       Wen = 1'b0;
  logic       Wlim = 1'b0;
  logic       Restore = 1'b0;
  logic       Inc = 1'b0;
  logic       Dec = 1'b0;
  logic [7:0] BusOut = '0;

  logic [7:0] m_dout, s_dout, f_dout, t_dout;
  logic       m_zero, s_zero, f_zero, t_zero;
  logic [3:0] m_done, s_done, f_done;
  logic [2:0] t_done;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  loop_cnt_bank u_main (
    .Clk(Clk), .RST(RST), .CH(CH), .Wen(Wen), .Wlim(Wlim), .Restore(Restore),
    .Inc(Inc), .Dec(Dec), .BusOut(BusOut), .dout(m_dout), .zero(m_zero), .done(m_done)
  );

  loop_cnt_bank #(.SAT(1)) u_sat (
    .Clk(Clk), .RST(RST), .CH(CH), .Wen(Wen), .Wlim(Wlim), .Restore(Restore),
    .Inc(Inc), .Dec(Dec), .BusOut(BusOut), .dout(s_dout), .zero(s_zero), .done(s_done)
  );

  loop_cnt_bank #(.STEP(4)) u_step4 (
    .Clk(Clk), .RST(RST), .CH(CH), .Wen(Wen), .Wlim(Wlim), .Restore(Restore),
    .Inc(Inc), .Dec(Dec), .BusOut(BusOut), .dout(f_dout), .zero(f_zero), .done(f_done)
  );

  loop_cnt_bank #(.N(3), .CW(2)) u_n3 (
    .Clk(Clk), .RST(RST), .CH(CH), .Wen(Wen), .Wlim(Wlim), .Restore(Restore),
    .Inc(Inc), .Dec(Dec), .BusOut(BusOut), .dout(t_dout), .zero(t_zero), .done(t_done)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One command cycle: drive, take the edge, sample 1 ns later, clear.
  task automatic cmd(input logic [1:0] ch, input logic wen, input logic wlim,
                     input logic rst_c, input logic inc, input logic dec,
                     input logic [7:0] bus);
    CH = ch; Wen = wen; Wlim = wlim; Restore = rst_c; Inc = inc; Dec = dec; BusOut = bus;
    @(posedge Clk);
    #1;
    Wen = 1'b0; Wlim = 1'b0; Restore = 1'b0; Inc = 1'b0; Dec = 1'b0;
  endtask

  task automatic do_reset(input logic wen, input logic [7:0] bus);
    RST = 1'b1; CH = 2'd0; Wen = wen; BusOut = bus;
    @(posedge Clk);
    #1;
    RST = 1'b0; Wen = 1'b0;
  endtask

  task automatic sel(input logic [1:0] ch);
    CH = ch;
    #1;
  endtask

  initial begin
    // Reset state
    do_reset(1'b0, 8'h00);
    check_val("rst_dout", 32'(m_dout), 32'h00);
    check_val("rst_zero", 32'(m_zero), 32'h1);
    check_val("rst_done", 32'(m_done), 32'h0);
    check_val("rst_n3_done", 32'(t_done), 32'h0);

    // Load, base capture, restore
    cmd(2'd1, 1, 0, 0, 0, 0, 8'h05);
    check_val("load_05", 32'(m_dout), 32'h05);
    check_val("load_05_zero", 32'(m_zero), 32'h0);
    cmd(2'd1, 1, 0, 0, 0, 0, 8'h09);
    check_val("load_09", 32'(m_dout), 32'h09);
    cmd(2'd1, 0, 0, 1, 0, 0, 8'h00);
    check_val("restore_base05", 32'(m_dout), 32'h05);

    // Wrap / saturate on channel 0
    cmd(2'd0, 1, 0, 0, 0, 0, 8'hFF);
    cmd(2'd0, 0, 0, 0, 1, 0, 8'h00);
    check_val("wrap_inc", 32'(m_dout), 32'h00);
    check_val("wrap_inc_zero", 32'(m_zero), 32'h1);
    check_val("sat_inc", 32'(s_dout), 32'hFF);
    check_val("sat_inc_done", 32'(s_done), 32'h1);
    check_val("step4_inc_wrap", 32'(f_dout), 32'h03);
    cmd(2'd0, 1, 0, 0, 0, 0, 8'h00);
    check_val("sat_wen_clr_done", 32'(s_done), 32'h0);
    cmd(2'd0, 0, 0, 0, 0, 1, 8'h00);
    check_val("sat_dec", 32'(s_dout), 32'h00);
    check_val("sat_dec_done", 32'(s_done), 32'h0);
    check_val("wrap_dec", 32'(m_dout), 32'hFF);
    check_val("wrap_dec_done", 32'(m_done), 32'h1);
    check_val("step4_dec_wrap", 32'(f_dout), 32'hFC);
    cmd(2'd0, 1, 0, 0, 0, 0, 8'h02);
    cmd(2'd0, 0, 0, 0, 0, 1, 8'h00);
    check_val("step4_dec_02", 32'(f_dout), 32'hFE);
    check_val("dec_02", 32'(m_dout), 32'h01);

    // Limit flag on channel 2
    do_reset(1'b0, 8'h00);
    cmd(2'd2, 0, 1, 0, 0, 0, 8'h03);
    cmd(2'd2, 1, 0, 0, 0, 0, 8'h00);
    cmd(2'd2, 0, 0, 0, 1, 0, 8'h00);
    cmd(2'd2, 0, 0, 0, 1, 0, 8'h00);
    check_val("lim_inc2_done", 32'(m_done), 32'h0);
    cmd(2'd2, 0, 0, 0, 1, 0, 8'h00);
    check_val("lim_inc3_done", 32'(m_done), 32'h4);
    check_val("lim_inc3_cnt", 32'(m_dout), 32'h03);
    cmd(2'd2, 0, 0, 0, 1, 0, 8'h00);
    cmd(2'd2, 0, 0, 0, 1, 0, 8'h00);
    check_val("lim_sticky_done", 32'(m_done), 32'h4);
    check_val("lim_sticky_cnt", 32'(m_dout), 32'h05);
    cmd(2'd2, 0, 0, 1, 0, 0, 8'h00);
    check_val("lim_restore_done", 32'(m_done), 32'h0);
    check_val("lim_restore_cnt", 32'(m_dout), 32'h00);

    // Wlim together with Inc: comparison uses the old limit (3)
    cmd(2'd2, 0, 1, 0, 1, 0, 8'h01);
    check_val("wlim_inc_cnt", 32'(m_dout), 32'h01);
    check_val("wlim_inc_old_lim", 32'(m_done), 32'h0);
    cmd(2'd2, 0, 0, 0, 1, 0, 8'h00);
    check_val("new_lim_miss", 32'(m_done), 32'h0);
    cmd(2'd2, 0, 0, 0, 0, 1, 8'h00);
    check_val("new_lim_hit", 32'(m_done), 32'h4);

    // Priority (base2 is 0x00; count2 is 0x01 so Wen leaves base alone)
    cmd(2'd2, 1, 0, 1, 1, 0, 8'h40);
    check_val("prio_wen", 32'(m_dout), 32'h40);
    check_val("prio_wen_clr_done", 32'(m_done), 32'h0);
    cmd(2'd2, 0, 0, 0, 1, 1, 8'h00);
    check_val("prio_inc_dec_hold", 32'(m_dout), 32'h40);
    cmd(2'd2, 0, 0, 1, 1, 0, 8'h00);
    check_val("prio_restore", 32'(m_dout), 32'h00);

    // Isolation and out-of-range channel on the N=3 instance
    do_reset(1'b0, 8'h00);
    cmd(2'd0, 1, 0, 0, 0, 0, 8'h10);
    cmd(2'd1, 1, 0, 0, 0, 0, 8'h20);
    cmd(2'd2, 1, 0, 0, 0, 0, 8'h30);
    cmd(2'd0, 0, 0, 0, 1, 0, 8'h00);
    check_val("iso_ch0", 32'(t_dout), 32'h11);
    sel(2'd1);
    check_val("iso_ch1", 32'(t_dout), 32'h20);
    sel(2'd2);
    check_val("iso_ch2", 32'(t_dout), 32'h30);
    sel(2'd3);
    check_val("oor_dout", 32'(t_dout), 32'h00);
    check_val("oor_zero", 32'(t_zero), 32'h1);
    cmd(2'd3, 1, 0, 0, 0, 0, 8'h55);
    check_val("oor_wen_dout", 32'(t_dout), 32'h00);
    sel(2'd0);
    check_val("oor_wen_ch0", 32'(t_dout), 32'h11);
    sel(2'd1);
    check_val("oor_wen_ch1", 32'(t_dout), 32'h20);
    sel(2'd2);
    check_val("oor_wen_ch2", 32'(t_dout), 32'h30);
    check_val("oor_done", 32'(t_done), 32'h0);

    // Reset mid-operation with a Wen in the reset cycle
    cmd(2'd0, 0, 1, 0, 0, 0, 8'h7A);
    cmd(2'd0, 1, 0, 0, 0, 0, 8'h79);
    cmd(2'd0, 0, 0, 0, 1, 0, 8'h00);
    check_val("mid_cnt", 32'(m_dout), 32'h7A);
    check_val("mid_done", 32'(m_done), 32'h1);
    do_reset(1'b1, 8'h33);
    check_val("mid_rst_cnt", 32'(m_dout), 32'h00);
    check_val("mid_rst_done", 32'(m_done), 32'h0);
    sel(2'd2);
    check_val("mid_rst_ch2", 32'(m_dout), 32'h00);
    // Limit back to 0xFF: stepping to 0xFF must set done
    cmd(2'd0, 1, 0, 0, 0, 0, 8'hFE);
    cmd(2'd0, 0, 0, 0, 1, 0, 8'h00);
    check_val("mid_rst_lim_ff", 32'(m_done), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
